// File: rtl/core_sequencer.sv
`default_nettype none
// core_sequencer: multi-cycle fetch/decode/execute controller for the 8-bit core.
// Define SEQ_MEM_WAIT_EN to add dm_ready and stall MEM until it is high.
module core_sequencer #(
  parameter int          PC_W   = 8,
  parameter int          DM_AW  = 4,
  parameter int unsigned RST_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [PC_W-1:0]  last_add,
  input  logic [7:0]       instr_in,
  input  logic             alu_z,
  input  logic             alu_cy,
  input  logic             alu_s,
  input  logic [7:0]       rf_rdata,
`ifdef SEQ_MEM_WAIT_EN
  input  logic             dm_ready,
`endif
  output logic [PC_W-1:0]  im_addr,
  output logic             im_rd,
  output logic [1:0]       rf_raddr,
  output logic [1:0]       rf_waddr,
  output logic             rf_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_we,
  output logic             dm_re,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic [3:0]       alu_op,
  output logic [7:0]       imm8,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_s,
  output logic             halted,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_MVI = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h7;
  localparam logic [3:0] OP_JMP = 4'hF;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [7:0]      ir_q;
  logic            flag_z_q, flag_c_q, flag_s_q;
  logic            im_rd_q, rf_we_q, dm_we_q, dm_re_q;
  logic            halted_q, alu_src_imm_q;
  logic [1:0]      rf_raddr_q, rf_waddr_q, wb_sel_q;

  logic       mem_go;
  logic       cond_ok;
  logic       jmp_taken;
  logic       retire;
  logic [3:0] op;
  logic [3:0] dec_op;

  assign op     = ir_q[7:4];
  assign dec_op = instr_in[7:4];

  function automatic logic is_imm_op(input logic [3:0] o);
    return (o == 4'h9) || ((o >= 4'hB) && (o <= 4'hE));
  endfunction

`ifdef SEQ_MEM_WAIT_EN
  assign mem_go = dm_ready;
`else
  assign mem_go = 1'b1;
`endif

  // Retire marks the last cycle of every instruction; PC and halt decisions hang off it.
  always_comb begin
    case (ir_q[1:0])
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = flag_z_q;
      2'b10:   cond_ok = flag_c_q;
      default: cond_ok = flag_s_q;
    endcase
    jmp_taken = (state_q == S_EXEC) && (op == OP_JMP) && cond_ok;
    retire    = (state_q == S_WB)
             || ((state_q == S_EXEC) && ((op == OP_CMP) || (op == OP_JMP)))
             || ((state_q == S_MEM) && (op == OP_ST) && mem_go);
    pc_d      = jmp_taken ? PC_W'(rf_rdata) : pc_q + PC_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_W'(RST_PC);
      ir_q          <= '0;
      flag_z_q      <= 1'b0;
      flag_c_q      <= 1'b0;
      flag_s_q      <= 1'b0;
      im_rd_q       <= 1'b0;
      rf_we_q       <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_re_q       <= 1'b0;
      halted_q      <= 1'b0;
      alu_src_imm_q <= 1'b0;
      rf_raddr_q    <= 2'd0;
      rf_waddr_q    <= 2'd0;
      wb_sel_q      <= 2'd0;
    end else begin
      im_rd_q <= 1'b0;
      rf_we_q <= 1'b0;
      dm_we_q <= 1'b0;
      dm_re_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            im_rd_q <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q          <= instr_in;
          rf_raddr_q    <= 2'd0;
          alu_src_imm_q <= 1'b0;
          case (dec_op)
            OP_LD: begin
              state_q <= S_MEM;
              dm_re_q <= 1'b1;
            end
            OP_ST: begin
              state_q <= S_MEM;
              dm_we_q <= 1'b1;
            end
            OP_MVI: begin
              state_q    <= S_WB;
              rf_we_q    <= 1'b1;
              wb_sel_q   <= 2'b01;
              rf_waddr_q <= instr_in[3:2];
            end
            OP_JMP: begin
              state_q    <= S_EXEC;
              rf_raddr_q <= instr_in[3:2];
            end
            default: begin
              state_q       <= S_EXEC;
              rf_raddr_q    <= instr_in[1:0];
              alu_src_imm_q <= is_imm_op(dec_op);
            end
          endcase
        end
        S_EXEC: begin
          if (op != OP_JMP) begin
            flag_z_q <= alu_z;
            flag_c_q <= alu_cy;
            flag_s_q <= alu_s;
          end
          if (!retire) begin
            state_q    <= S_WB;
            rf_we_q    <= 1'b1;
            wb_sel_q   <= 2'b10;
            rf_waddr_q <= ir_q[3:2];
          end
        end
        S_MEM: begin
          if (!mem_go) begin
            dm_re_q <= dm_re_q;
            dm_we_q <= dm_we_q;
          end else if (!retire) begin
            state_q    <= S_WB;
            rf_we_q    <= 1'b1;
            wb_sel_q   <= 2'b00;
            rf_waddr_q <= 2'd0;
          end
        end
        S_WB, S_HALT: ;
        default: state_q <= S_IDLE;
      endcase
      // A taken jump at last_add still loads its target before halting.
      if (retire) begin
        if (pc_q == last_add) begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
          if (jmp_taken) pc_q <= pc_d;
        end else begin
          state_q <= S_FETCH;
          im_rd_q <= 1'b1;
          pc_q    <= pc_d;
        end
      end
    end
  end

  assign im_addr     = pc_q;
  assign im_rd       = im_rd_q;
  assign rf_raddr    = rf_raddr_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_we       = rf_we_q;
  assign dm_addr     = DM_AW'(ir_q[3:0]);
  assign dm_we       = dm_we_q;
  assign dm_re       = dm_re_q;
  assign wb_sel      = wb_sel_q;
  assign alu_src_imm = alu_src_imm_q;
  assign alu_op      = ir_q[7:4];
  assign imm8        = {{6{ir_q[1]}}, ir_q[1:0]};
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign flag_s      = flag_s_q;
  assign halted      = halted_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// tb_core_sequencer: scoreboard bench; a program-level reference model predicts every strobe.
module tb_core_sequencer;

  localparam int K_FETCH = 0;
  localparam int K_DMRE  = 1;
  localparam int K_DMWE  = 2;
  localparam int K_RFWE  = 3;
  localparam int K_EXEC  = 4;
  localparam int K_HALT  = 5;

  typedef struct {
    int cyc;
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic [7:0] last_add = 8'd0;
  logic [7:0] instr_in, rf_rdata;
  logic       alu_z, alu_cy, alu_s;
`ifdef SEQ_MEM_WAIT_EN
  logic       dm_ready = 1'b1;
`endif
  logic [7:0] im_addr;
  logic       im_rd, rf_we, dm_we, dm_re, alu_src_imm;
  logic [1:0] rf_raddr, rf_waddr, wb_sel;
  logic [3:0] dm_addr, alu_op;
  logic [7:0] imm8;
  logic       flag_z, flag_c, flag_s, halted;
  logic [2:0] state;

  logic [7:0] prog [256];
  logic [2:0] ftab [256];
  logic [7:0] regs [4];

  ev_t q[$];
  ev_t mq[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  final_pc = 0;
  bit  prev_halted = 1'b0;

  core_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .last_add(last_add),
    .instr_in(instr_in), .alu_z(alu_z), .alu_cy(alu_cy), .alu_s(alu_s),
    .rf_rdata(rf_rdata),
`ifdef SEQ_MEM_WAIT_EN
    .dm_ready(dm_ready),
`endif
    .im_addr(im_addr), .im_rd(im_rd), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .dm_addr(dm_addr), .dm_we(dm_we), .dm_re(dm_re),
    .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op), .imm8(imm8),
    .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s), .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: instruction memory, ALU flags per address, register bank.
  assign instr_in = prog[im_addr];
  assign {alu_z, alu_cy, alu_s} = ftab[im_addr];
  assign rf_rdata = regs[rf_raddr];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int cy, input int k, input int a, input int b, input int c);
    ev_t e;
    e.cyc = cy; e.kind = k; e.a = a; e.b = b; e.c = c;
    return e;
  endfunction

  task automatic observe(input int kind, input int a, input int b, input int c);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d a=%0d got at cycle %0d, expected none", kind, a, cyc);
      return;
    end
    e = q.pop_front();
    chk($sformatf("ev%0d_kind", e.kind), kind, e.kind);
    chk($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
    chk($sformatf("ev%0d_a", e.kind), a, e.a);
    if (e.b >= 0) chk($sformatf("ev%0d_b", e.kind), b, e.b);
    if (e.c >= 0) chk($sformatf("ev%0d_c", e.kind), c, e.c);
  endtask

  always @(negedge clk) begin
    if (im_rd) observe(K_FETCH, int'(im_addr), 0, 0);
    if (dm_re) observe(K_DMRE, int'(dm_addr), int'(rf_raddr), 0);
    if (dm_we) observe(K_DMWE, int'(dm_addr), int'(rf_raddr), 0);
    if (rf_we) observe(K_RFWE, int'(rf_waddr), int'(wb_sel), int'(imm8));
    if (state == 3'd3) observe(K_EXEC, int'(rf_raddr), int'(alu_src_imm), int'(alu_op));
    if (halted && !prev_halted)
      observe(K_HALT, int'(im_addr), int'({flag_z, flag_c, flag_s}), 0);
    prev_halted = halted;
  end

  // Instruction-level model: walks the program, emitting each strobe at its cycle.
  task automatic model_run(input int t0, output bit ok);
    int pc, t, op, rd, rs, len, imm8v, tgt, v;
    bit fz, fc, fs, taken;
    logic [7:0] ir;
    mq.delete();
    ok = 1'b0; pc = 0; t = t0; fz = 0; fc = 0; fs = 0;
    for (int n = 0; n < 150; n++) begin
      ir = prog[pc];
      op = int'(ir[7:4]); rd = int'(ir[3:2]); rs = int'(ir[1:0]);
      v = rs; if (v >= 2) v = v - 4; imm8v = v & 255;
      taken = 0; tgt = 0;
      mq.push_back(mk(t, K_FETCH, pc, -1, -1));
      if (op == 0) begin
        mq.push_back(mk(t + 2, K_DMRE, int'(ir[3:0]), -1, -1));
        mq.push_back(mk(t + 3, K_RFWE, 0, 0, -1));
        len = 4;
      end else if (op == 1) begin
        mq.push_back(mk(t + 2, K_DMWE, int'(ir[3:0]), 0, -1));
        len = 3;
      end else if (op == 2) begin
        mq.push_back(mk(t + 2, K_RFWE, rd, 1, imm8v));
        len = 3;
      end else if (op == 15) begin
        mq.push_back(mk(t + 2, K_EXEC, rd, -1, 15));
        case (rs)
          0: taken = 1;
          1: taken = fz;
          2: taken = fc;
          default: taken = fs;
        endcase
        tgt = int'(regs[rd]);
        len = 3;
      end else begin
        mq.push_back(mk(t + 2, K_EXEC, rs,
                        (op == 7) ? -1 : ((op inside {9, 11, 12, 13, 14}) ? 1 : 0), op));
        if (op != 7) mq.push_back(mk(t + 3, K_RFWE, rd, 2, -1));
        {fz, fc, fs} = ftab[pc];
        len = (op == 7) ? 3 : 4;
      end
      if (pc == int'(last_add)) begin
        if (taken) pc = tgt;
        mq.push_back(mk(t + len, K_HALT, pc, int'({fz, fc, fs}), -1));
        final_pc = pc;
        ok = 1'b1;
        return;
      end
      pc = taken ? tgt : (pc + 1) % 256;
      t = t + len;
    end
  endtask

  task automatic clear_tables();
    foreach (prog[i]) prog[i] = 8'h00;
    foreach (ftab[i]) ftab[i] = 3'b000;
    foreach (regs[i]) regs[i] = 8'h00;
  endtask

  task automatic start_prog();
    bit ok;
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run = 1'b1;
    model_run(cyc + 1, ok);
    foreach (mq[i]) q.push_back(mq[i]);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (q.size() > 0 && i < 2000) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));
      i++;
    end
    repeat (4) @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
    chk("halt_level", int'(halted), 1);
    chk("halt_pc", int'(im_addr), final_pc);
    q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int i;
    // Reset state with run held high, then LD followed by MVI.
    clear_tables();
    prog[0] = 8'h05;
    prog[1] = 8'h2E;
    last_add = 8'h01;
    reset = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_pc", int'(im_addr), 0);
    chk("rst_strobes", int'({im_rd, rf_we, dm_we, dm_re}), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_wbsel", int'(wb_sel), 0);
    chk("rst_srcimm", int'(alu_src_imm), 0);
    chk("rst_flags", int'({flag_z, flag_c, flag_s}), 0);
    reset = 1'b1;
    model_run(cyc + 1, ok);
    foreach (mq[k]) q.push_back(mq[k]);
    @(negedge clk);
    chk("fetch_after_release", int'(state), 1);
    drain();

    // CMP sets Z, then JMP Z via R1 is taken.
    clear_tables();
    prog[0] = 8'h70; ftab[0] = 3'b100;
    prog[1] = 8'hF5; regs[1] = 8'h20;
    prog[8'h20] = 8'h2E;
    last_add = 8'h20;
    start_prog(); drain();

    // Same with Z clear: jump falls through.
    clear_tables();
    prog[0] = 8'h70; ftab[0] = 3'b011;
    prog[1] = 8'hF5; regs[1] = 8'h20;
    prog[2] = 8'h2E;
    last_add = 8'h02;
    start_prog(); drain();

    // Three MVIs, halt at last_add=2.
    clear_tables();
    prog[0] = 8'h2E; prog[1] = 8'h29; prog[2] = 8'h27;
    last_add = 8'h02;
    start_prog(); drain();

    // Taken jump located at last_add: target loaded, still halts.
    clear_tables();
    prog[0] = 8'hF0; regs[0] = 8'h33;
    last_add = 8'h00;
    start_prog(); drain();

    // PC wraps 0xFF -> 0x00; conditional jump not taken first visit, taken second.
    clear_tables();
    prog[0] = 8'hF1; regs[0] = 8'h10;
    prog[1] = 8'hF4; regs[1] = 8'hFF;
    prog[8'hFF] = 8'h70; ftab[8'hFF] = 3'b100;
    prog[8'h10] = 8'h2E;
    last_add = 8'h10;
    start_prog(); drain();

    // Reset pulsed during EXEC of ADD: no register write may follow.
    clear_tables();
    prog[0] = 8'h31;
    last_add = 8'h00;
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; run = 1'b1;
    q.push_back(mk(cyc + 1, K_FETCH, 0, -1, -1));
    q.push_back(mk(cyc + 3, K_EXEC, 1, 0, 3));
    i = 0;
    while (state != 3'd3 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("reached_exec", int'(state), 3);
    #1 reset = 1'b0;
    run = 1'b0;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_rf_we", int'(rf_we), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_idle_hold", int'(state), 0);
    chk("midrst_queue", q.size(), 0);
    q.delete();

    // Randomised programs against the model.
    for (int r = 0; r < 20; r++) begin
      ok = 1'b0;
      for (int tries = 0; tries < 50 && !ok; tries++) begin
        foreach (prog[k]) prog[k] = 8'($urandom);
        foreach (ftab[k]) ftab[k] = 3'($urandom);
        foreach (regs[k]) regs[k] = 8'($urandom_range(0, 48));
        last_add = 8'($urandom_range(0, 40));
        model_run(0, ok);
      end
      if (ok) begin
        start_prog();
        drain();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
